// File: rtl/reg_file.sv
// Two-read, one-write register file with write-to-read bypass.
// Register 0 has no storage and always reads zero.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WRITE_REG,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];
  logic              wr_en;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  assign wr_en = RegWrite && (WRITE_REG != '0);

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (WRITE_REG == ADDR_W'(i))) begin
        regs_d[i] = write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Storage lookup by loop so index 0 never touches the array.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (read_reg1 == ADDR_W'(i)) stored1 = regs_q[i];
      if (read_reg2 == ADDR_W'(i)) stored2 = regs_q[i];
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (rst_n) begin
      if (read_reg1 != '0) begin
        read_data1 = (wr_en && (read_reg1 == WRITE_REG)) ? write_data : stored1;
      end
      if (read_reg2 != '0) begin
        read_data2 = (wr_en && (read_reg2 == WRITE_REG)) ? write_data : stored2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, bypass, r0 protection, sweep.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WRITE_REG;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int checks;
  int failures;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWrite   (RegWrite),
    .WRITE_REG  (WRITE_REG),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    RegWrite   = 1'b1;
    WRITE_REG  = addr;
    write_data = data;
    @(posedge clk);
    #1;
    RegWrite   = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
    read_reg1 = a1;
    read_reg2 = a2;
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    RegWrite   = 1'b0;
    WRITE_REG  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;

    // Reset active: bypass disabled, writes ignored
    @(negedge clk);
    RegWrite = 1'b1; WRITE_REG = 5'd5; write_data = 32'hCAFEF00D;
    do_read(5'd5, 5'd5);
    check("rst_bypass1", read_data1, 32'h0);
    check("rst_bypass2", read_data2, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(5'd5, 5'd0);
    check("rst_write_ignored", read_data1, 32'h0);
    check("r0_after_rst", read_data2, 32'h0);

    // Reset clear is asynchronous
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd5);
    check("r5_written", read_data1, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    check("async_clear", read_data1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("clear_after_rise", read_data1, 32'h0);
    @(posedge clk);
    #1;
    check("clear_after_edge", read_data1, 32'h0);

    // Write then read next cycle on both ports
    do_write(5'd7, 32'h12345678);
    do_read(5'd7, 5'd7);
    check("r7_port1", read_data1, 32'h12345678);
    check("r7_port2", read_data2, 32'h12345678);

    // Same-cycle bypass
    do_write(5'd3, 32'h11111111);
    do_write(5'd4, 32'h00000004);
    @(negedge clk);
    RegWrite = 1'b1; WRITE_REG = 5'd3; write_data = 32'h22222222;
    do_read(5'd3, 5'd4);
    check("bypass_p1", read_data1, 32'h22222222);
    check("bypass_p2_other", read_data2, 32'h00000004);
    do_read(5'd4, 5'd3);
    check("bypass_p2", read_data2, 32'h22222222);
    check("bypass_p1_other", read_data1, 32'h00000004);
    do_read(5'd3, 5'd3);
    check("bypass_both1", read_data1, 32'h22222222);
    check("bypass_both2", read_data2, 32'h22222222);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    do_read(5'd3, 5'd4);
    check("r3_stored", read_data1, 32'h22222222);
    check("r4_stored", read_data2, 32'h00000004);

    // Register 0 protection
    @(negedge clk);
    RegWrite = 1'b1; WRITE_REG = 5'd0; write_data = 32'hFFFFFFFF;
    do_read(5'd0, 5'd0);
    check("r0_bypass1", read_data1, 32'h0);
    check("r0_bypass2", read_data2, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("r0_stored1", read_data1, 32'h0);
    check("r0_stored2", read_data2, 32'h0);

    // Write disabled
    do_write(5'd9, 32'h00000009);
    @(negedge clk);
    RegWrite = 1'b0; WRITE_REG = 5'd9; write_data = 32'hAAAA5555;
    do_read(5'd9, 5'd9);
    check("wr_dis_no_bypass", read_data1, 32'h00000009);
    @(posedge clk);
    #1;
    check("wr_dis_kept", read_data2, 32'h00000009);

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 1; i < 32; i++) begin
      do_read(5'(i), 5'(32 - i));
      check($sformatf("sweep_p1_r%0d", i), read_data1, 32'(i) * 32'h01010101);
      check($sformatf("sweep_p2_r%0d", 32 - i), read_data2, 32'(32 - i) * 32'h01010101);
    end
    do_read(5'd0, 5'd31);
    check("sweep_r0", read_data1, 32'h0);
    check("sweep_r31", read_data2, 32'h1F1F1F1F);

    // Reset falling during a pending write loses the write
    @(negedge clk);
    RegWrite = 1'b1; WRITE_REG = 5'd12; write_data = 32'h5A5A5A5A;
    #1 rst_n = 1'b0;
    do_read(5'd12, 5'd1);
    check("midwrite_rd", read_data1, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(5'd12, 5'd1);
    check("midwrite_lost", read_data1, 32'h0);
    check("midwrite_r1_cleared", read_data2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
